// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between the CPU io_master port and the SRAM responder.
// master drives requests and write data; slave returns ready, data and responses.
interface axi4_sram_slave_if #(
    parameter int ID_W = 4
);
    logic            awvalid;
    logic            awready;
    logic [31:0]     awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;

    logic            wvalid;
    logic            wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;

    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    modport slave (
        input  awvalid, awaddr, awid,
        input  awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid,
        input  arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awid,
        output awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid,
        output arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 SRAM responder: independent read/write engines, FIXED/INCR/WRAP bursts.
// Define AXI4_SRAM_SLAVE_DECERR_EN to answer out-of-range beats with DECERR.
module axi4_sram_slave #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS  = 4096,
    parameter int          ID_W       = 4,
    parameter int          RD_LATENCY = 1
) (
    input logic             clk,
    input logic             rst,
    axi4_sram_slave_if.slave s
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W =
        (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_END =
        LAT_W'(RD_LATENCY - 1);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [1:0] clamp_size(
        input logic [2:0] sz
    );
        clamp_size = (sz > 3'd2) ? 2'd2 : sz[1:0];
    endfunction

    function automatic logic [31:0] next_addr(
        input logic [31:0] a,
        input logic [7:0]  len,
        input logic [1:0]  sz,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] incr;
        logic [31:0] mask;
        logic        wrap_ok;
        step    = 32'd1 << sz;
        incr    = a + step;
        wrap_ok = (burst == BURST_WRAP) &&
                  ((len == 8'd1) || (len == 8'd3) ||
                   (len == 8'd7) || (len == 8'd15));
        // container is (len+1)*step bytes, aligned to itself
        mask = (({24'd0, len} + 32'd1) << sz) - 32'd1;
        unique case (1'b1)
            (burst == BURST_FIXED): next_addr = a;
            wrap_ok:
                next_addr = (a & ~mask) | (incr & mask);
            default: next_addr = incr;
        endcase
    endfunction

    logic [31:0] mem [MEM_WORDS];

    // write engine state
    logic [1:0]      w_state;
    logic [31:0]     w_addr;
    logic [ID_W-1:0] w_id;
    logic [7:0]      w_len;
    logic [1:0]      w_size;
    logic [1:0]      w_burst;
    logic [7:0]      w_beat;
    logic            w_err;
    logic            w_dec;
    logic            aw_rdy;
    logic            w_rdy;
    logic            b_vld;
    logic [1:0]      b_resp;
    logic [ID_W-1:0] b_id;

    // read engine state
    logic [1:0]       r_state;
    logic [31:0]      r_addr;
    logic [ID_W-1:0]  r_id;
    logic [7:0]       r_len;
    logic [1:0]       r_size;
    logic [1:0]       r_burst;
    logic [7:0]       r_beat;
    logic [LAT_W-1:0] r_cnt;
    logic             ar_rdy;
    logic             r_vld;
    logic [31:0]      r_data;
    logic [1:0]       r_resp;
    logic             r_last;

    logic [31:0]      w_next;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_oor;
    logic             w_fire;
    logic             w_is_last;
    logic             w_mis;

    logic [31:0]      r_next;
    logic [31:0]      r_load;
    logic [31:0]      r_off;
    logic [IDX_W-1:0] r_idx;
    logic             r_oor;
    logic [31:0]      r_word;
    logic [1:0]       r_rsp;
    logic [7:0]       r_beat_nx;

    logic             unused_ok;

    assign w_next = next_addr(w_addr, w_len,
                              w_size, w_burst);
    assign w_off  = w_addr - ADDR_BASE;
    assign w_idx  = w_off[IDX_W+1:2];

    assign w_fire    = (w_state == W_DATA) &&
                       s.wvalid && w_rdy;
    assign w_is_last = (w_beat == w_len);
    assign w_mis     = (s.wlast != w_is_last);

    assign r_next = next_addr(r_addr, r_len,
                              r_size, r_burst);
    // first beat loads from the start address,
    // later beats load ahead from the advanced one
    assign r_load = (r_state == R_WAIT) ?
                    r_addr : r_next;
    assign r_off  = r_load - ADDR_BASE;
    assign r_idx  = r_off[IDX_W+1:2];

    assign r_beat_nx = r_beat + 8'd1;

`ifdef AXI4_SRAM_SLAVE_DECERR_EN
    localparam logic [32:0] MEM_BYTES =
        33'(MEM_WORDS) << 2;
    assign w_oor = ({1'b0, w_off} >= MEM_BYTES);
    assign r_oor = ({1'b0, r_off} >= MEM_BYTES);
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    assign r_word = r_oor ? 32'h0 : mem[r_idx];
    assign r_rsp  = r_oor ? RESP_DECERR : RESP_OKAY;

    assign unused_ok = ^{w_off, r_off};

    always_ff @(posedge clk) begin
        if (w_fire && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (s.wstrb[i])
                    mem[w_idx][8*i +: 8] <=
                        s.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_dec   <= 1'b0;
            aw_rdy  <= 1'b0;
            w_rdy   <= 1'b0;
            b_vld   <= 1'b0;
            b_resp  <= '0;
            b_id    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_rdy && s.awvalid) begin
                        w_addr  <= s.awaddr;
                        w_id    <= s.awid;
                        w_len   <= s.awlen;
                        w_size  <= clamp_size(s.awsize);
                        w_burst <= s.awburst;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        w_dec   <= 1'b0;
                        aw_rdy  <= 1'b0;
                        w_rdy   <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        aw_rdy <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_mis) w_err <= 1'b1;
                        if (w_oor) w_dec <= 1'b1;
                        if (w_is_last) begin
                            w_rdy   <= 1'b0;
                            b_vld   <= 1'b1;
                            b_id    <= w_id;
                            // DECERR outranks SLVERR
                            b_resp  <= (w_dec || w_oor) ?
                                RESP_DECERR :
                                (w_err || w_mis) ?
                                RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_addr <= w_next;
                            w_beat <= w_beat + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s.bready) begin
                        b_vld   <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
            ar_rdy  <= 1'b0;
            r_vld   <= 1'b0;
            r_data  <= '0;
            r_resp  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_rdy && s.arvalid) begin
                        r_addr  <= s.araddr;
                        r_id    <= s.arid;
                        r_len   <= s.arlen;
                        r_size  <= clamp_size(s.arsize);
                        r_burst <= s.arburst;
                        r_beat  <= '0;
                        r_cnt   <= '0;
                        ar_rdy  <= 1'b0;
                        r_state <= R_WAIT;
                    end else begin
                        ar_rdy <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == LAT_END) begin
                        r_data  <= r_word;
                        r_resp  <= r_rsp;
                        r_last  <= (r_len == 8'd0);
                        r_vld   <= 1'b1;
                        r_state <= R_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (s.rready) begin
                        if (r_last) begin
                            r_vld   <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_beat <= r_beat_nx;
                            r_data <= r_word;
                            r_resp <= r_rsp;
                            r_last <= (r_beat_nx == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s.awready = aw_rdy;
    assign s.wready  = w_rdy;
    assign s.bvalid  = b_vld;
    assign s.bresp   = b_resp;
    assign s.bid     = b_id;
    assign s.arready = ar_rdy;
    assign s.rvalid  = r_vld;
    assign s.rdata   = r_data;
    assign s.rresp   = r_resp;
    assign s.rlast   = r_last;
    assign s.rid     = r_id;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: vector table of single-beat
// write/read pairs plus hand sequences for bursts, stalls and reset.
module tb_axi4_sram_slave;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_sram_slave_if #(.ID_W(4)) bus ();

    axi4_sram_slave #(
        .ADDR_BASE (32'h8000_0000),
        .MEM_WORDS (4096),
        .ID_W      (4),
        .RD_LATENCY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus)
    );

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] raddr;
        logic [31:0] init;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  id;
        logic [31:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic [3:0]  rid_got;
    int          lat_got;
    int          gap_max;

    logic [1:0]  resp;
    logic [3:0]  bid;
    vec_t        vt[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic axi_write(
        input  logic [31:0] addr,
        input  logic [3:0]  id,
        input  logic [7:0]  len,
        input  logic [1:0]  burst,
        input  int          last_at,
        output logic [1:0]  o_resp,
        output logic [3:0]  o_bid
    );
        int t;
        bus.awaddr  = addr;
        bus.awid    = id;
        bus.awlen   = len;
        bus.awsize  = 3'd2;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("aw_handshake", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = wbuf[i];
            bus.wstrb  = sbuf[i];
            bus.wlast  = (i == last_at);
            bus.wvalid = 1'b1;
            t = 0;
            while (!bus.wready && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("w_handshake", 32'(bus.wready), 32'd1);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        bus.bready = 1'b1;
        t = 0;
        while (!bus.bvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("b_handshake", 32'(bus.bvalid), 32'd1);
        o_resp = bus.bresp;
        o_bid  = bus.bid;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(
        input logic [31:0] addr,
        input logic [3:0]  id,
        input logic [7:0]  len,
        input logic [1:0]  burst,
        input int          stall_at
    );
        int t;
        bus.rready  = 1'b1;
        bus.araddr  = addr;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = 3'd2;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ar_handshake", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        lat_got = 0;
        while (!bus.rvalid && lat_got < 50) begin
            @(negedge clk);
            lat_got++;
        end
        gap_max = 0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!bus.rvalid && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t > gap_max) gap_max = t;
            rbuf[i] = bus.rdata;
            rrsp[i] = bus.rresp;
            rlst[i] = bus.rlast;
            rid_got = bus.rid;
            if (i == stall_at) begin
                bus.rready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_rvalid",
                        32'(bus.rvalid), 32'd1);
                    chk("stall_rdata", bus.rdata, rbuf[i]);
                    chk("stall_rlast",
                        32'(bus.rlast), 32'(rlst[i]));
                end
                bus.rready = 1'b1;
            end
            @(negedge clk);
        end
        chk("no_extra_beat", 32'(bus.rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0;
        bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0;
        bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        vt.push_back('{32'h8000_0010, 32'h8000_0010,
            32'h1122_3344, 32'hDEAD_BEEF, 4'b0101,
            4'h3, 32'h11AD_33EF});
        vt.push_back('{32'h8000_0020, 32'h8000_0020,
            32'hAAAA_AAAA, 32'h1234_5678, 4'b1010,
            4'h7, 32'h12AA_56AA});
        vt.push_back('{32'h8000_0024, 32'h8000_0024,
            32'h0000_0000, 32'hFFFF_FFFF, 4'b1111,
            4'hA, 32'hFFFF_FFFF});
        vt.push_back('{32'h8000_3FFC, 32'h8000_3FFC,
            32'h0102_0304, 32'hCAFE_F00D, 4'b0000,
            4'hC, 32'h0102_0304});
        vt.push_back('{32'h8000_0102, 32'h8000_0100,
            32'h5566_7788, 32'h0000_AB00, 4'b0010,
            4'h1, 32'h5566_AB88});
`ifndef AXI4_SRAM_SLAVE_DECERR_EN
        vt.push_back('{32'h8000_4004, 32'h8000_0004,
            32'h0BAD_F00D, 32'h0000_0000, 4'b0000,
            4'h2, 32'h0BAD_F00D});
`endif

        repeat (2) @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_valids",
            32'({bus.bvalid, bus.rvalid, bus.rlast}), 32'd0);
        chk("rst_bresp_bid",
            32'({bus.bresp, bus.bid}), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rresp_rid",
            32'({bus.rresp, bus.rid}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("awready_after_rst", 32'(bus.awready), 32'd1);
        chk("arready_after_rst", 32'(bus.arready), 32'd1);

        foreach (vt[n]) begin
            wbuf[0] = vt[n].init;
            sbuf[0] = 4'hF;
            axi_write(vt[n].waddr, vt[n].id, 8'd0, 2'd1,
                      0, resp, bid);
            chk("vec_init_bresp", 32'(resp), 32'd0);
            wbuf[0] = vt[n].wdata;
            sbuf[0] = vt[n].strb;
            axi_write(vt[n].waddr, vt[n].id, 8'd0, 2'd1,
                      0, resp, bid);
            chk("vec_bresp", 32'(resp), 32'd0);
            chk("vec_bid", 32'(bid), 32'(vt[n].id));
            axi_read(vt[n].raddr, vt[n].id, 8'd0, 2'd1, -1);
            chk("vec_rdata", rbuf[0], vt[n].exp);
            chk("vec_rresp", 32'(rrsp[0]), 32'd0);
            chk("vec_rlast", 32'(rlst[0]), 32'd1);
            chk("vec_rid", 32'(rid_got), 32'(vt[n].id));
            chk("vec_latency", 32'(lat_got), 32'd3);
        end

        // WRAP write lands 0x08,0x0C,0x00,0x04
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h0;
            sbuf[i] = 4'hF;
        end
        axi_write(32'h8000_0000, 4'h1, 8'd3, 2'd1, 3,
                  resp, bid);
        chk("clr_bresp", 32'(resp), 32'd0);
        for (int i = 0; i < 4; i++)
            wbuf[i] = 32'hA0A0_0000 + 32'(i);
        axi_write(32'h8000_0008, 4'h2, 8'd3, 2'd2, 3,
                  resp, bid);
        chk("wrap_bresp", 32'(resp), 32'd0);
        chk("wrap_bid", 32'(bid), 32'h2);

        axi_read(32'h8000_0000, 4'h6, 8'd3, 2'd1, -1);
        chk("incr_latency", 32'(lat_got), 32'd3);
        chk("incr_gap", 32'(gap_max), 32'd0);
        chk("incr_rid", 32'(rid_got), 32'h6);
        chk("incr_d0", rbuf[0], 32'hA0A0_0002);
        chk("incr_d1", rbuf[1], 32'hA0A0_0003);
        chk("incr_d2", rbuf[2], 32'hA0A0_0000);
        chk("incr_d3", rbuf[3], 32'hA0A0_0001);
        chk("incr_rlast",
            32'({rlst[0], rlst[1], rlst[2], rlst[3]}),
            32'b0001);

        axi_read(32'h8000_0008, 4'h7, 8'd3, 2'd2, -1);
        chk("wrapr_d0", rbuf[0], 32'hA0A0_0000);
        chk("wrapr_d1", rbuf[1], 32'hA0A0_0001);
        chk("wrapr_d2", rbuf[2], 32'hA0A0_0002);
        chk("wrapr_d3", rbuf[3], 32'hA0A0_0003);

        axi_read(32'h8000_0004, 4'h8, 8'd2, 2'd0, -1);
        chk("fixed_d0", rbuf[0], 32'hA0A0_0003);
        chk("fixed_d2", rbuf[2], 32'hA0A0_0003);
        chk("fixed_rlast",
            32'({rlst[0], rlst[1], rlst[2]}), 32'b001);

        // wlast early on beat 1 of a 3-beat burst
        for (int i = 0; i < 3; i++) begin
            wbuf[i] = 32'hB0B0_0000 + 32'(i);
            sbuf[i] = 4'hF;
        end
        axi_write(32'h8000_0040, 4'h5, 8'd2, 2'd1, 1,
                  resp, bid);
        chk("early_wlast_bresp", 32'(resp), 32'h2);
        chk("early_wlast_bid", 32'(bid), 32'h5);
        axi_read(32'h8000_0040, 4'h9, 8'd2, 2'd1, 1);
        chk("stall_d0", rbuf[0], 32'hB0B0_0000);
        chk("stall_d1", rbuf[1], 32'hB0B0_0001);
        chk("stall_d2", rbuf[2], 32'hB0B0_0002);
        chk("stall_rlast",
            32'({rlst[0], rlst[1], rlst[2]}), 32'b001);

        // missing wlast, then a clean burst clears the flag
        axi_write(32'h8000_0050, 4'hE, 8'd1, 2'd1, -1,
                  resp, bid);
        chk("no_wlast_bresp", 32'(resp), 32'h2);
        chk("no_wlast_bid", 32'(bid), 32'hE);
        axi_write(32'h8000_0050, 4'hD, 8'd1, 2'd1, 1,
                  resp, bid);
        chk("clean_bresp", 32'(resp), 32'h0);

        // async reset in the middle of a read burst
        bus.rready  = 1'b0;
        bus.araddr  = 32'h8000_0000;
        bus.arid    = 4'h4;
        bus.arlen   = 8'd7;
        bus.arsize  = 3'd2;
        bus.arburst = 2'd1;
        bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        for (int t = 0; t < 20 && !bus.rvalid; t++)
            @(negedge clk);
        chk("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("async_rst_arready", 32'(bus.arready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arready_after_release",
            32'(bus.arready), 32'd1);
        axi_read(32'h8000_0010, 4'hB, 8'd0, 2'd1, -1);
        chk("post_rst_rdata", rbuf[0], 32'h11AD_33EF);
        chk("post_rst_rlast", 32'(rlst[0]), 32'd1);
        chk("post_rst_rid", 32'(rid_got), 32'hB);

`ifdef AXI4_SRAM_SLAVE_DECERR_EN
        axi_read(32'h0000_0000, 4'h1, 8'd0, 2'd1, -1);
        chk("decerr_rresp", 32'(rrsp[0]), 32'h3);
        chk("decerr_rdata", rbuf[0], 32'h0);
        wbuf[0] = 32'h1234_5678;
        sbuf[0] = 4'hF;
        axi_write(32'h0000_0000, 4'h2, 8'd0, 2'd1, 0,
                  resp, bid);
        chk("decerr_bresp", 32'(resp), 32'h3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
